s298_resp_misr: RTL and testbench
=================================

Name: s298_resp_misr

Overview:
- Downstream response compactor for the s298 sequential benchmark core.
- Samples the core's 6 primary outputs each qualified cycle and folds them into a 16-bit Galois MISR signature.
- Counts samples and reports completion via a START/DONE handshake.
- Lets benches and encrypted-evaluation flows check a whole s298 run with a single 16-bit compare.

Parameters:
- NSAMP, 16, number of VALID samples per run; legal range 1..65535.
- SEED, 16'h0000, MISR value loaded at reset and at each START.
- POLY, 16'h0039, Galois feedback taps (x^16+x^5+x^4+x^3+1).

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RN  input  1  reset; synchronous, active-low.
- START  input  1  begin a run; honoured in IDLE or DONE only.
- VALID  input  1  RESP is a valid s298 output sample this cycle.
- RESP  input  6  core outputs packed {G117,G118,G132,G133,G66,G67}; bit 5 = G117.
- BUSY  output  1  high while in RUN.
- DONE  output  1  high in DONE; held until START or reset.
- SIG  output  16  current MISR signature; registered.
- CNT  output  16  samples absorbed in the current run; registered.

Behaviour:
- Reset: RN low at a CK edge gives state=IDLE, SIG=SEED, CNT=0, BUSY=0, DONE=0. This applies in any state, including mid-run; a partial signature is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE + START: SIG<=SEED, CNT<=0, go to RUN next cycle. Otherwise hold.
  - RUN + VALID: SIG<=(SIG<<1) ^ (SIG[15] ? POLY : 0) ^ {10'b0,RESP}; CNT<=CNT+1.
  - RUN + VALID with CNT==NSAMP-1: the same update occurs and the next state is DONE.
  - RUN + !VALID: hold SIG and CNT.
  - START during RUN is ignored.
  - DONE: hold SIG and CNT. START reloads SEED, clears CNT and returns to RUN. DONE drops the same edge that BUSY rises.
- VALID is ignored in IDLE and DONE. VALID on the same cycle as the accepted START is also ignored; the first sample is taken the cycle after START.
- Latency: a sample on edge k appears in SIG after edge k. DONE and the final SIG are visible together after the edge that absorbs the NSAMP-th sample.
- Arithmetic: the shift discards bit 15 after it is used as feedback. CNT never wraps because the run ends at NSAMP.
- Outputs are pure register outputs, with no combinational path from inputs.

Optional Feature:
- Macro: S298_RESP_MISR_CMP_EN.
- Defined:
  - Adds parameter GOLDEN (16, default 16'h0000).
  - Adds output PASS (1 bit, registered).
  - PASS is written on the edge entering DONE, with value (next SIG==GOLDEN). It is cleared to 0 on reset and on each START.
- Undefined: no GOLDEN parameter and no PASS port; the rest of the behaviour is identical.

Decomposition:
- Package s298_resp_pkg holds:
  - RESP_W=6 and SIG_W=16;
  - the default POLY constant;
  - the state enum {ST_IDLE, ST_RUN, ST_DONE}.
- One sub-module, misr16: a combinational next-signature function of (sig, resp, poly). The top owns the registers, FSM and counter.

Test Plan:
- Reset/idle: hold RN low for 2 cycles, then RN=1 with no START → SIG=0000, CNT=0, BUSY=0, DONE=0 for 10 cycles; VALID with RESP=3F leaves SIG unchanged.
- Single sample, NSAMP=1: START, then VALID with RESP=2A next cycle → SIG=002A, CNT=1, DONE=1, BUSY=0 after that edge.
- Shift, NSAMP=2: samples 3F then 00 → SIG=003F, then 007E; DONE rises only after the second sample.
- Feedback, SEED=8000, NSAMP=1: RESP=00 → SIG=0039. Gaps with VALID=0 between START and the sample do not change the result.
- Mid-run reset and restart: NSAMP=4, abort after 2 samples with RN=0 → SIG=SEED, CNT=0. START in DONE reloads SEED and clears DONE; START during RUN has no effect.
- CMP_EN: GOLDEN=002A, NSAMP=1, RESP=2A → PASS=1. Rerun with RESP=2B → PASS=0; PASS=0 during RUN.

Source files
------------

// File: rtl/s298_resp_misr_pkg.sv
// Shared constants and types for the s298 response MISR.
// Optional compare feature is enabled by defining S298_RESP_MISR_CMP_EN.
package s298_resp_pkg;

  localparam int RESP_W = 6;
  localparam int SIG_W  = 16;

  // x^16 + x^5 + x^4 + x^3 + 1, Galois taps
  localparam logic [SIG_W-1:0] POLY_DEF = 16'h0039;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/s298_resp_misr_misr16.sv
// Combinational next-signature for a 16-bit Galois MISR.
// Bit 15 is used as feedback and then shifted out; the sample is XORed
// into the low bits.
module misr16
  import s298_resp_pkg::*;
(
  input  logic [SIG_W-1:0]  sig_i,
  input  logic [RESP_W-1:0] resp_i,
  input  logic [SIG_W-1:0]  poly_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] fb;

  // Feedback taps apply only when the outgoing MSB is set
  always_comb begin
    fb    = sig_i[SIG_W-1] ? poly_i : '0;
    sig_o = {sig_i[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-RESP_W){1'b0}}, resp_i};
  end

endmodule

// File: rtl/s298_resp_misr.sv
// s298 response compactor: folds qualified 6-bit samples into a 16-bit
// MISR signature, counts samples, and signals completion with START/DONE.
// Define S298_RESP_MISR_CMP_EN to add the GOLDEN parameter and PASS output.
//
// Handshake: START is honoured only in IDLE or DONE and moves to RUN on the
// next edge. In RUN, every cycle with VALID=1 absorbs RESP; the edge that
// absorbs sample NSAMP moves to DONE. VALID outside RUN (including the cycle
// START is accepted) is ignored. DONE is held until START or reset.
module s298_resp_misr
  import s298_resp_pkg::*;
#(
  parameter int unsigned       NSAMP = 16,
  parameter logic [SIG_W-1:0]  SEED  = 16'h0000,
  parameter logic [SIG_W-1:0]  POLY  = POLY_DEF
`ifdef S298_RESP_MISR_CMP_EN
  , parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
`endif
)
(
  input  logic              CK,
  input  logic              RN,
  input  logic              START,
  input  logic              VALID,
  input  logic [RESP_W-1:0] RESP,
  output logic              BUSY,
  output logic              DONE,
  output logic [SIG_W-1:0]  SIG,
  output logic [15:0]       CNT
`ifdef S298_RESP_MISR_CMP_EN
  , output logic            PASS
`endif
);

  localparam logic [15:0] LAST_CNT = 16'(NSAMP - 1);

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SIG_W-1:0] sig_nxt;

  misr16 u_misr (
    .sig_i  (sig_q),
    .resp_i (RESP),
    .poly_i (POLY),
    .sig_o  (sig_nxt)
  );

  // Next-state, signature and counter update
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_RUN;
          sig_d   = SEED;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (VALID) begin
          sig_d = sig_nxt;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, signature, counter and flag registers
  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef S298_RESP_MISR_CMP_EN
  logic pass_q;

  // Verdict captured on the edge entering DONE, cleared on each START
  always_ff @(posedge CK) begin
    if (!RN) begin
      pass_q <= 1'b0;
    end else if (state_q == ST_RUN && state_d == ST_DONE) begin
      pass_q <= (sig_d == GOLDEN);
    end else if (state_q != ST_RUN && START) begin
      pass_q <= 1'b0;
    end
  end

  assign PASS = pass_q;
`endif

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign SIG  = sig_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_s298_resp_misr.sv
// Bench for s298_resp_misr: four instances with different NSAMP/SEED share
// one stimulus stream and are checked against a sample-level model.
// Define S298_RESP_MISR_CMP_EN to also check PASS.
module tb_s298_resp_misr;

  localparam int NI = 4;

  // ---------------- clock / reset ----------------
  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       START = 1'b0;
  logic       VALID = 1'b0;
  logic [5:0] RESP = '0;

  always #5 CK = ~CK;

  logic        busy_w [NI];
  logic        done_w [NI];
  logic [15:0] sig_w  [NI];
  logic [15:0] cnt_w  [NI];
`ifdef S298_RESP_MISR_CMP_EN
  logic        pass_w [NI];
`endif

  // Per-instance configuration as the model sees it
  int          p_nsamp  [NI] = '{1, 2, 1, 4};
  logic [15:0] p_seed   [NI] = '{16'h0000, 16'h0000, 16'h8000, 16'hACE1};
  logic [15:0] p_golden [NI] = '{16'h002A, 16'h0000, 16'h0000, 16'h0000};

`ifdef S298_RESP_MISR_CMP_EN
  s298_resp_misr #(.NSAMP(1), .SEED(16'h0000), .GOLDEN(16'h002A)) u_a (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[0]), .DONE(done_w[0]), .SIG(sig_w[0]), .CNT(cnt_w[0]), .PASS(pass_w[0]));
  s298_resp_misr #(.NSAMP(2), .SEED(16'h0000)) u_b (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[1]), .DONE(done_w[1]), .SIG(sig_w[1]), .CNT(cnt_w[1]), .PASS(pass_w[1]));
  s298_resp_misr #(.NSAMP(1), .SEED(16'h8000)) u_c (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[2]), .DONE(done_w[2]), .SIG(sig_w[2]), .CNT(cnt_w[2]), .PASS(pass_w[2]));
  s298_resp_misr #(.NSAMP(4), .SEED(16'hACE1)) u_d (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[3]), .DONE(done_w[3]), .SIG(sig_w[3]), .CNT(cnt_w[3]), .PASS(pass_w[3]));
`else
  s298_resp_misr #(.NSAMP(1), .SEED(16'h0000)) u_a (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[0]), .DONE(done_w[0]), .SIG(sig_w[0]), .CNT(cnt_w[0]));
  s298_resp_misr #(.NSAMP(2), .SEED(16'h0000)) u_b (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[1]), .DONE(done_w[1]), .SIG(sig_w[1]), .CNT(cnt_w[1]));
  s298_resp_misr #(.NSAMP(1), .SEED(16'h8000)) u_c (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[2]), .DONE(done_w[2]), .SIG(sig_w[2]), .CNT(cnt_w[2]));
  s298_resp_misr #(.NSAMP(4), .SEED(16'hACE1)) u_d (
    .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP),
    .BUSY(busy_w[3]), .DONE(done_w[3]), .SIG(sig_w[3]), .CNT(cnt_w[3]));
`endif

  // ---------------- reference model ----------------
  // m_run: run in progress; m_fin: run completed and not yet restarted.
  bit          m_run  [NI];
  bit          m_fin  [NI];
  logic [15:0] m_sig  [NI];
  int          m_cnt  [NI];
  bit          m_pass [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Signature arithmetic: double mod 2^16, apply taps if the top bit fell off, add sample
  function automatic logic [15:0] fold(input logic [15:0] s, input logic [5:0] r);
    int t;
    t = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) t = t ^ 32'h0039;
    t = t ^ int'(r);
    return t[15:0];
  endfunction

  task automatic model_edge(input logic rn, input logic st, input logic v, input logic [5:0] r);
    for (int i = 0; i < NI; i++) begin
      if (!rn) begin
        m_run[i] = 0; m_fin[i] = 0; m_sig[i] = p_seed[i]; m_cnt[i] = 0; m_pass[i] = 0;
      end else if (m_run[i]) begin
        if (v) begin
          m_sig[i] = fold(m_sig[i], r);
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == p_nsamp[i]) begin
            m_run[i] = 0; m_fin[i] = 1; m_pass[i] = (m_sig[i] == p_golden[i]);
          end
        end
      end else if (st) begin
        m_run[i] = 1; m_fin[i] = 0; m_sig[i] = p_seed[i]; m_cnt[i] = 0; m_pass[i] = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("m%0d_sig", i),  {16'h0, sig_w[i]},  {16'h0, m_sig[i]});
      chk($sformatf("m%0d_cnt", i),  {16'h0, cnt_w[i]},  m_cnt[i]);
      chk($sformatf("m%0d_busy", i), {31'h0, busy_w[i]}, {31'h0, m_run[i]});
      chk($sformatf("m%0d_done", i), {31'h0, done_w[i]}, {31'h0, m_fin[i]});
`ifdef S298_RESP_MISR_CMP_EN
      chk($sformatf("m%0d_pass", i), {31'h0, pass_w[i]}, {31'h0, m_pass[i]});
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic st, input logic v, input logic [5:0] r);
    RN = rn; START = st; VALID = v; RESP = r;
    @(posedge CK);
    model_edge(rn, st, v, r);
    #1;
    check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset held two cycles, then idle with stray VALIDs
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b0, 1'b0, 1'b0, 6'h00);
    chk("rst_sig", {16'h0, sig_w[0]}, 32'h0000);
    chk("rst_cnt", {16'h0, cnt_w[0]}, 32'h0);
    chk("rst_busy", {31'h0, busy_w[0]}, 32'h0);
    chk("rst_done", {31'h0, done_w[0]}, 32'h0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, k[0], 6'h3F);
    chk("idle_sig", {16'h0, sig_w[0]}, 32'h0000);
    chk("idle_seed_c", {16'h0, sig_w[2]}, 32'h8000);

    // Single sample, NSAMP=1
    step(1'b1, 1'b1, 1'b1, 6'h15);   // VALID with accepted START is ignored
    chk("start_busy", {31'h0, busy_w[0]}, 32'h1);
    chk("start_sig", {16'h0, sig_w[0]}, 32'h0000);
    step(1'b1, 1'b0, 1'b1, 6'h2A);
    chk("one_sig", {16'h0, sig_w[0]}, 32'h002A);
    chk("one_cnt", {16'h0, cnt_w[0]}, 32'h1);
    chk("one_done", {31'h0, done_w[0]}, 32'h1);
    chk("one_busy", {31'h0, busy_w[0]}, 32'h0);

    // Shift, NSAMP=2
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b1, 6'h3F);
    chk("shift1_sig", {16'h0, sig_w[1]}, 32'h003F);
    chk("shift1_done", {31'h0, done_w[1]}, 32'h0);
    step(1'b1, 1'b0, 1'b1, 6'h00);
    chk("shift2_sig", {16'h0, sig_w[1]}, 32'h007E);
    chk("shift2_done", {31'h0, done_w[1]}, 32'h1);

    // Feedback, SEED=8000, with gaps before the sample
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 6'h3F);
    step(1'b1, 1'b0, 1'b1, 6'h00);
    chk("fb_sig", {16'h0, sig_w[2]}, 32'h0039);
    chk("fb_done", {31'h0, done_w[2]}, 32'h1);

    // Mid-run reset on NSAMP=4
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b1, 6'h11);
    step(1'b1, 1'b0, 1'b1, 6'h22);
    chk("mid_cnt", {16'h0, cnt_w[3]}, 32'h2);
    step(1'b0, 1'b0, 1'b1, 6'h33);
    chk("abort_sig", {16'h0, sig_w[3]}, 32'hACE1);
    chk("abort_cnt", {16'h0, cnt_w[3]}, 32'h0);
    chk("abort_busy", {31'h0, busy_w[3]}, 32'h0);

    // START during RUN ignored, START in DONE restarts
    step(1'b1, 1'b1, 1'b0, 6'h00);
    step(1'b1, 1'b0, 1'b1, 6'h05);
    step(1'b1, 1'b1, 1'b1, 6'h06);
    chk("run_start_cnt", {16'h0, cnt_w[3]}, 32'h2);
    step(1'b1, 1'b0, 1'b1, 6'h07);
    step(1'b1, 1'b0, 1'b1, 6'h08);
    chk("d_done", {31'h0, done_w[3]}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    chk("restart_done", {31'h0, done_w[3]}, 32'h0);
    chk("restart_busy", {31'h0, busy_w[3]}, 32'h1);
    chk("restart_sig", {16'h0, sig_w[3]}, 32'hACE1);
    chk("restart_cnt", {16'h0, cnt_w[3]}, 32'h0);

`ifdef S298_RESP_MISR_CMP_EN
    // Golden compare on instance A (GOLDEN=002A)
    step(1'b0, 1'b0, 1'b0, 6'h00);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    chk("pass_run", {31'h0, pass_w[0]}, 32'h0);
    step(1'b1, 1'b0, 1'b1, 6'h2A);
    chk("pass_hit", {31'h0, pass_w[0]}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 6'h00);
    chk("pass_clr", {31'h0, pass_w[0]}, 32'h0);
    step(1'b1, 1'b0, 1'b1, 6'h2B);
    chk("pass_miss", {31'h0, pass_w[0]}, 32'h0);
`endif

    // Randomized traffic with occasional resets and STARTs
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0), 6'($urandom_range(0, 63)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
